// File: rtl/sample_load_sequencer.sv
// rtl/sample_load_sequencer.sv - serial byte stream to sample-storage load sequencer
//
// Purpose:
//   Builds 12-byte samples from the UART receive stream. Each sample holds
//   4 input bytes, 4 expected-output bytes and 4 valid-output bytes, in that
//   order, with lane [0] being the first byte of each field. Every finished
//   sample goes to the storage FSM through a prepare/write handshake, tagged
//   with an incrementing index. A load covers indices 0..NUM_SAMPLES and then
//   reports completion.
//
// Ports:
//   iClock                 system clock, rising edge
//   iReset_n               asynchronous active-low reset
//   iStart                 start pulse, accepted only in IDLE or DONE
//   iRxData / iRxValid     received byte and its one-cycle strobe
//   iNextSample            storage FSM idle/ready
//   oPreparingNextSample   one-cycle prepare pulse to storage
//   oWriteSample           one-cycle write pulse; storage latches data + index
//   oSampleIndex           index of the sample being written
//   oSerialInput           assembled input bytes (lane 0 = first byte)
//   oSerialExpectedOutput  assembled expected-output bytes
//   oSerialValidOutput     assembled valid-output bytes
//   oBusy                  high outside IDLE and DONE
//   oDone                  high in DONE
//   oError                 sticky inter-byte timeout flag
//   oDroppedByte           sticky flag: a byte arrived outside RX

module sample_load_sequencer #(
    parameter int unsigned NUM_SAMPLES    = 16,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic            iClock,
    input  logic            iReset_n,
    input  logic            iStart,
    input  logic [7:0]      iRxData,
    input  logic            iRxValid,
    input  logic            iNextSample,
    output logic            oPreparingNextSample,
    output logic            oWriteSample,
    output logic [31:0]     oSampleIndex,
    output logic [3:0][7:0] oSerialInput,
    output logic [3:0][7:0] oSerialExpectedOutput,
    output logic [3:0][7:0] oSerialValidOutput,
    output logic            oBusy,
    output logic            oDone,
    output logic            oError,
    output logic            oDroppedByte
);

    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] LAST_INDEX   = 32'(NUM_SAMPLES);
    localparam logic [3:0]  LAST_BYTE    = 4'd11;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        RX         = 3'd1,
        WAIT_READY = 3'd2,
        PREPARE    = 3'd3,
        WRITE      = 3'd4,
        WAIT_ACK   = 3'd5,
        DONE       = 3'd6
    } state_t;

    state_t      state;
    state_t      stateNext;
    logic [3:0]  byteCount;
    logic [31:0] timeoutCount;

    logic startAccepted;
    logic sampleComplete;
    logic timeoutHit;

    always_comb begin
        startAccepted  = iStart && ((state == IDLE) || (state == DONE));
        sampleComplete = (state == RX) && iRxValid && (byteCount == LAST_BYTE);
        // A byte on the terminal-count cycle takes priority over the timeout.
        timeoutHit     = (state == RX) && !iRxValid && (byteCount != 4'd0)
                         && (timeoutCount == TIMEOUT_LAST);
    end

    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext            = state;
        oPreparingNextSample = 1'b0;
        oWriteSample         = 1'b0;
        oBusy                = 1'b1;
        oDone                = 1'b0;
        case (state)
            IDLE: begin
                oBusy = 1'b0;
                if (iStart) begin
                    stateNext = RX;
                end
            end
            RX: begin
                if (sampleComplete) begin
                    stateNext = WAIT_READY;
                end else if (timeoutHit) begin
                    stateNext = IDLE;
                end
            end
            WAIT_READY: begin
                if (iNextSample) begin
                    stateNext = PREPARE;
                end
            end
            PREPARE: begin
                oPreparingNextSample = 1'b1;
                stateNext            = WRITE;
            end
            WRITE: begin
                oWriteSample = 1'b1;
                stateNext    = WAIT_ACK;
            end
            WAIT_ACK: begin
                // Storage returning to idle acknowledges the write.
                if (iNextSample) begin
                    stateNext = (oSampleIndex == LAST_INDEX) ? DONE : RX;
                end
            end
            DONE: begin
                oBusy = 1'b0;
                oDone = 1'b1;
                if (iStart) begin
                    stateNext = RX;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            byteCount             <= 4'd0;
            timeoutCount          <= 32'd0;
            oSampleIndex          <= 32'd0;
            oSerialInput          <= '0;
            oSerialExpectedOutput <= '0;
            oSerialValidOutput    <= '0;
            oError                <= 1'b0;
            oDroppedByte          <= 1'b0;
        end else begin
            // A byte arriving with an accepted start is dropped, but the start
            // clears the flag in the same cycle, so it stays low.
            if (startAccepted) begin
                oSampleIndex <= 32'd0;
                byteCount    <= 4'd0;
                timeoutCount <= 32'd0;
                oError       <= 1'b0;
                oDroppedByte <= 1'b0;
            end else if (iRxValid && (state != RX)) begin
                oDroppedByte <= 1'b1;
            end

            if (state == RX) begin
                if (iRxValid) begin
                    case (byteCount[3:2])
                        2'd0:    oSerialInput[byteCount[1:0]]          <= iRxData;
                        2'd1:    oSerialExpectedOutput[byteCount[1:0]] <= iRxData;
                        2'd2:    oSerialValidOutput[byteCount[1:0]]    <= iRxData;
                        default: ;
                    endcase
                    timeoutCount <= 32'd0;
                    byteCount    <= (byteCount == LAST_BYTE) ? 4'd0 : byteCount + 4'd1;
                end else if (byteCount != 4'd0) begin
                    // Only a partially received sample can time out.
                    if (timeoutCount == TIMEOUT_LAST) begin
                        oError       <= 1'b1;
                        byteCount    <= 4'd0;
                        timeoutCount <= 32'd0;
                    end else begin
                        timeoutCount <= timeoutCount + 32'd1;
                    end
                end
            end

            if ((state == WAIT_ACK) && iNextSample && (oSampleIndex != LAST_INDEX)) begin
                oSampleIndex <= oSampleIndex + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_sample_load_sequencer.sv
// tb/tb_sample_load_sequencer.sv - self-checking bench for sample_load_sequencer

module tb_sample_load_sequencer;

    localparam int NUM = 16;
    localparam int TMO = 100;

    logic            iClock = 1'b0;
    logic            iReset_n = 1'b0;
    logic            iStart = 1'b0;
    logic [7:0]      iRxData = 8'h00;
    logic            iRxValid = 1'b0;
    logic            iNextSample = 1'b0;
    logic            oPreparingNextSample;
    logic            oWriteSample;
    logic [31:0]     oSampleIndex;
    logic [3:0][7:0] oSerialInput;
    logic [3:0][7:0] oSerialExpectedOutput;
    logic [3:0][7:0] oSerialValidOutput;
    logic            oBusy;
    logic            oDone;
    logic            oError;
    logic            oDroppedByte;

    sample_load_sequencer #(
        .NUM_SAMPLES    (NUM),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .iClock                (iClock),
        .iReset_n              (iReset_n),
        .iStart                (iStart),
        .iRxData               (iRxData),
        .iRxValid              (iRxValid),
        .iNextSample           (iNextSample),
        .oPreparingNextSample  (oPreparingNextSample),
        .oWriteSample          (oWriteSample),
        .oSampleIndex          (oSampleIndex),
        .oSerialInput          (oSerialInput),
        .oSerialExpectedOutput (oSerialExpectedOutput),
        .oSerialValidOutput    (oSerialValidOutput),
        .oBusy                 (oBusy),
        .oDone                 (oDone),
        .oError                (oError),
        .oDroppedByte          (oDroppedByte)
    );

    always #5 iClock = ~iClock;

    typedef struct {
        logic [31:0] idx;
        logic [31:0] inp;
        logic [31:0] exo;
        logic [31:0] vao;
    } sample_t;

    sample_t expQ[$];
    int      nChecks = 0;
    int      nErrors = 0;
    int      nWrites = 0;
    int      nPrep   = 0;
    logic    prevPrep = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nErrors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Storage-side observer: every write must follow a prepare and match the
    // next sample the model expects, in order.
    always @(negedge iClock) begin
        if (oPreparingNextSample) nPrep++;
        if (oWriteSample) begin
            sample_t e;
            nWrites++;
            check("write_after_prepare", prevPrep, 1);
            check("write_expected", expQ.size() != 0, 1);
            if (expQ.size() != 0) begin
                e = expQ.pop_front();
                check("write_index", oSampleIndex, e.idx);
                check("write_input", oSerialInput, e.inp);
                check("write_expected_out", oSerialExpectedOutput, e.exo);
                check("write_valid_out", oSerialValidOutput, e.vao);
            end
        end
        prevPrep = oPreparingNextSample;
    end

    task automatic tick();
        @(posedge iClock);
        #1;
    endtask

    task automatic sendByte(input logic [7:0] b);
        iRxData  = b;
        iRxValid = 1'b1;
        tick();
        iRxValid = 1'b0;
    endtask

    task automatic pulseStart(input bit withByte);
        iStart = 1'b1;
        if (withByte) begin
            iRxValid = 1'b1;
            iRxData  = 8'h5A;
        end
        tick();
        iStart   = 1'b0;
        iRxValid = 1'b0;
    endtask

    // Sends one sample, plays the storage side, and returns with the
    // sequencer back in RX (or in DONE after the last index).
    task automatic loadSample(input int idx, input bit countBytes, input bit dropInWrite,
                              input bit startMid, input int readyDelay);
        logic [7:0] bytes [12];
        sample_t    s;
        int         ackDelay;
        for (int b = 0; b < 12; b++) begin
            bytes[b] = countBytes ? 8'(b + 1) : 8'($urandom);
        end
        s.idx = 32'(idx);
        s.inp = {bytes[3], bytes[2], bytes[1], bytes[0]};
        s.exo = {bytes[7], bytes[6], bytes[5], bytes[4]};
        s.vao = {bytes[11], bytes[10], bytes[9], bytes[8]};
        expQ.push_back(s);
        iNextSample = 1'b0;
        for (int b = 0; b < 12; b++) begin
            repeat ($urandom_range(0, 2)) tick();
            sendByte(bytes[b]);
            if (startMid && b == 5) pulseStart(1'b0);
        end
        for (int w = 0; w < readyDelay; w++) begin
            check("wait_ready_no_pulse", {oPreparingNextSample, oWriteSample}, 0);
            check("wait_ready_input_stable", oSerialInput, s.inp);
            check("wait_ready_valid_stable", oSerialValidOutput, s.vao);
            tick();
        end
        iNextSample = 1'b1;
        tick();
        check("prepare_one_after_ready", {oPreparingNextSample, oWriteSample}, 2'b10);
        tick();
        check("write_two_after_ready", {oPreparingNextSample, oWriteSample}, 2'b01);
        if (dropInWrite) begin
            iRxValid = 1'b1;
            iRxData  = 8'hEE;
        end
        iNextSample = 1'b0;
        tick();
        iRxValid = 1'b0;
        if (dropInWrite) check("dropped_in_write", oDroppedByte, 1);
        ackDelay = $urandom_range(0, 3);
        repeat (ackDelay) tick();
        check("wait_ack_busy_notdone", {oBusy, oDone}, 2'b10);
        check("wait_ack_index", oSampleIndex, 32'(idx));
        iNextSample = 1'b1;
        tick();
        if (idx == NUM) begin
            check("done_after_last_ack", {oBusy, oDone}, 2'b01);
            check("done_index_holds", oSampleIndex, 32'(NUM));
        end else begin
            check("next_index", oSampleIndex, 32'(idx + 1));
            check("rx_busy", {oBusy, oDone}, 2'b10);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        int cyc;

        // Reset state
        repeat (2) tick();
        check("reset_flags", {oPreparingNextSample, oWriteSample, oBusy, oDone, oError, oDroppedByte}, 0);
        check("reset_index", oSampleIndex, 0);
        check("reset_input", oSerialInput, 0);
        iReset_n = 1'b1;
        tick();
        check("idle_flags", {oBusy, oDone, oError, oDroppedByte}, 0);

        // Byte in IDLE is dropped; a start with a byte clears and keeps flag low
        sendByte(8'h33);
        check("dropped_in_idle", oDroppedByte, 1);
        pulseStart(1'b1);
        check("start_clears_drop", oDroppedByte, 0);
        check("start_busy", {oBusy, oDone}, 2'b10);

        // Counting pattern, then a full load with stalls, a drop and a stray start
        w0 = nWrites;
        loadSample(0, 1'b1, 1'b0, 1'b0, 0);
        for (int i = 1; i <= NUM; i++) begin
            loadSample(i, 1'b0, (i == 5), (i == 8), (i == 1) ? 20 : int'($urandom_range(0, 3)));
        end
        check("full_load_writes", nWrites - w0, NUM + 1);
        check("prep_equals_writes", nPrep, nWrites);
        check("full_load_no_error", oError, 0);
        check("full_load_queue_empty", expQ.size(), 0);

        // Restart from DONE, one sample, then timeout mid-sample at index 1
        pulseStart(1'b0);
        check("restart_index", oSampleIndex, 0);
        check("restart_flags", {oDone, oDroppedByte}, 0);
        loadSample(0, 1'b0, 1'b0, 1'b0, 0);
        for (int b = 0; b < 5; b++) begin
            repeat ($urandom_range(0, 2)) tick();
            sendByte(8'($urandom));
        end
        cyc = 0;
        while (!oError && cyc < 300) begin
            tick();
            cyc++;
        end
        check("timeout_cycles", cyc, TMO);
        check("timeout_idle", {oBusy, oDone, oError}, 3'b001);
        check("timeout_index_held", oSampleIndex, 1);

        pulseStart(1'b0);
        check("start_clears_error", oError, 0);
        check("start_after_timeout_index", oSampleIndex, 0);
        for (int i = 0; i < 3; i++) loadSample(i, 1'b0, 1'b0, 1'b0, int'($urandom_range(0, 2)));

        // Reset asserted while in PREPARE
        iNextSample = 1'b0;
        for (int b = 0; b < 12; b++) sendByte(8'($urandom));
        iNextSample = 1'b1;
        tick();
        check("prepare_before_reset", oPreparingNextSample, 1);
        w0 = nWrites;
        #2;
        iReset_n = 1'b0;
        #1;
        check("async_reset_flags", {oPreparingNextSample, oWriteSample, oBusy, oDone, oError, oDroppedByte}, 0);
        check("async_reset_index", oSampleIndex, 0);
        check("async_reset_data", {oSerialInput, oSerialExpectedOutput}, 0);
        check("async_reset_valid", oSerialValidOutput, 0);
        tick();
        tick();
        iReset_n = 1'b1;
        repeat (10) tick();
        check("no_write_after_reset", nWrites - w0, 0);
        check("idle_after_reset", oBusy, 0);
        pulseStart(1'b0);
        loadSample(0, 1'b0, 1'b0, 1'b0, 1);
        loadSample(1, 1'b1, 1'b0, 1'b0, 0);
        check("final_queue_empty", expQ.size(), 0);
        check("final_prep_equals_writes", nPrep, nWrites);

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule

// File: doc/sample_load_sequencer.md
Name: sample_load_sequencer

Overview:
- Controller that feeds the chromosome sample-storage state machine from a serial byte stream (UART receiver output).
- Assembles each sample from 12 received bytes (4 input, 4 expected-output, 4 valid-output) and drives the storage FSM's prepare/write handshake with an incrementing sample index.
- Loads indices 0..NUM_SAMPLES, then reports completion; detects inter-byte timeout and dropped bytes.
- Sits between the UART RX and the storage FSM; top level starts it once per dataset.

Parameters:
- NUM_SAMPLES, 16, highest sample index; a full load is NUM_SAMPLES+1 samples.
- TIMEOUT_CYCLES, 50000, maximum idle clocks between bytes of one sample before abort; width 32 bits.

Ports:
- iClock  in  1  system clock; all state on rising edge.
- iReset_n  in  1  asynchronous active-low reset.
- iStart  in  1  single-cycle pulse; begins a load at index 0; ignored unless in IDLE or DONE.
- iRxData  in  8  received byte.
- iRxValid  in  1  single-cycle strobe; iRxData valid this cycle.
- iNextSample  in  1  storage FSM is idle and ready (its oNextSample).
- oPreparingNextSample  out  1  one-cycle pulse to storage FSM.
- oWriteSample  out  1  one-cycle pulse; storage latches the data and index outputs.
- oSampleIndex  out  32  index of the sample being written.
- oSerialInput  out  4x8  assembled input bytes.
- oSerialExpectedOutput  out  4x8  assembled expected-output bytes.
- oSerialValidOutput  out  4x8  assembled valid-output bytes.
- oBusy  out  1  high in any state except IDLE and DONE.
- oDone  out  1  high in DONE; cleared by iStart or reset.
- oError  out  1  sticky timeout flag; cleared by iStart or reset.
- oDroppedByte  out  1  sticky; an iRxValid arrived outside RX; cleared by iStart or reset.

Behaviour:
- Reset: state IDLE. All outputs 0, including data registers, oSampleIndex, and the internal byte counter (4 bits) and timeout counter.
- States: IDLE, RX, WAIT_READY, PREPARE, WRITE, WAIT_ACK, DONE.
- IDLE/DONE + iStart: go to RX. Clear oSampleIndex, byte counter, timeout counter, oDone, oError and oDroppedByte.
- RX:
  - Each iRxValid stores iRxData at byte counter b, then increments b.
  - b 0-3 -> oSerialInput[b].
  - b 4-7 -> oSerialExpectedOutput[b-4].
  - b 8-11 -> oSerialValidOutput[b-8].
  - Lane [0] is the first byte of each field.
  - When the 12th byte is stored (b==11): reset b to 0 and go to WAIT_READY.
- Timeout (RX only):
  - The counter runs only while b!=0. It resets to 0 on every accepted byte.
  - If it reaches TIMEOUT_CYCLES-1 with no byte: set oError, go to IDLE, reset b. oSampleIndex is held for diagnosis.
  - If a byte arrives in the same cycle as the terminal count, the byte wins: it is accepted and no timeout occurs.
- WAIT_READY: when iNextSample==1, go to PREPARE.
- PREPARE: oPreparingNextSample=1 for exactly this cycle; next state WRITE.
- WRITE: oWriteSample=1 for exactly this cycle. oSerial*, oSampleIndex are stable from WAIT_READY through the end of WRITE. Next state WAIT_ACK.
- WAIT_ACK: when iNextSample==1 (storage back in idle):
  - If oSampleIndex==NUM_SAMPLES: go to DONE; index holds.
  - Otherwise: oSampleIndex+1, go to RX.
- Bytes arriving in WAIT_READY, PREPARE, WRITE or WAIT_ACK are discarded and set oDroppedByte. The same applies in IDLE/DONE, except in the cycle iStart is accepted; a byte in that cycle is also dropped, and the flag is cleared by that iStart, so the flag stays 0.
- iStart in any busy state: ignored.
- Minimum per-sample overhead after the 12th byte, with iNextSample held high: WAIT_READY, PREPARE, WRITE, WAIT_ACK = 4 cycles. The first byte of the next sample is accepted from the following cycle.
- Async reset mid-operation: immediate return to reset values. No partial write pulse may appear after reset deasserts.

Test Plan:
- Reset, then iStart with 12 bytes 0x01..0x0C (iNextSample=1): oSerialInput={0x04,0x03,0x02,0x01} as [3:0], expected {0x08..0x05}, valid {0x0C..0x09}. Exactly one prepare pulse, then one write pulse on the next cycle with oSampleIndex=0.
- Full load of 17 samples (NUM_SAMPLES=16) with storage model: indices 0..16 written in order, each exactly once. oDone rises after the 17th WAIT_ACK; oBusy falls in the same cycle.
- Storage holds iNextSample=0 for 20 cycles after the 12th byte: sequencer stays in WAIT_READY, no pulses, data stable. Pulses occur 1 and 2 cycles after iNextSample rises.
- Send 5 bytes, then silence (TIMEOUT_CYCLES=100): oError=1 exactly 100 cycles after the 5th byte, state IDLE. A following iStart clears oError and restarts at index 0.
- Byte sent during WRITE: oDroppedByte=1, written data unchanged, next sample's byte 0 is the first byte received after returning to RX.
- Assert iReset_n low while in PREPARE: all outputs 0 asynchronously; no oWriteSample after release; iStart restarts cleanly.
